// File: rtl/hsid_x_batch_fsm_if.sv
// OBI read-request channel between the batch sequencer (master) and the memory reader (slave).
// Supplies fallback values for the HSID_* width defaults when no project-wide header defines them.
`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 32
`endif
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif
`ifndef HSID_MEM_ACCESS_WIDTH
`define HSID_MEM_ACCESS_WIDTH 16
`endif

interface hsid_x_batch_fsm_if #(
  parameter int WORD_WIDTH       = `HSID_WORD_WIDTH,
  parameter int MEM_ACCESS_WIDTH = `HSID_MEM_ACCESS_WIDTH
);
  logic [WORD_WIDTH-1:0]       obi_initial_addr;
  logic [MEM_ACCESS_WIDTH-1:0] obi_limit_in;
  logic                        obi_start;
  logic                        obi_done;

  modport master (
    output obi_initial_addr,
    output obi_limit_in,
    output obi_start,
    input  obi_done
  );

  modport slave (
    input  obi_initial_addr,
    input  obi_limit_in,
    input  obi_start,
    output obi_done
  );
endinterface

// File: rtl/hsid_x_batch_fsm.sv
// Per-pixel batch sequencer: captured read, library read, wait for compute, advance; one state step per cycle, all outputs registered.
// Waits on obi_done/pixel_done indefinitely unless HSID_X_BATCH_TIMEOUT_EN adds a watchdog; clear/error abort from any busy state.
`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 32
`endif
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif
`ifndef HSID_MEM_ACCESS_WIDTH
`define HSID_MEM_ACCESS_WIDTH 16
`endif

module hsid_x_batch_fsm #(
  parameter int WORD_WIDTH        = `HSID_WORD_WIDTH,
  parameter int HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
  parameter int MEM_ACCESS_WIDTH  = `HSID_MEM_ACCESS_WIDTH,
  parameter int BATCH_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
  input  logic [BATCH_WIDTH-1:0]       batch_size,
  input  logic [WORD_WIDTH-1:0]        captured_pixel_addr,
  input  logic [WORD_WIDTH-1:0]        library_pixel_addr,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         error,
  input  logic                         pixel_done,
  hsid_x_batch_fsm_if.master           obi,
  output logic                         busy,
  output logic [BATCH_WIDTH-1:0]       pixel_index,
  output logic                         cfg_err,
  output logic                         timeout_err,
  output logic                         interrupt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONFIG    = 3'd1,
    START_CAP = 3'd2,
    READ_CAP  = 3'd3,
    START_LIB = 3'd4,
    READ_LIB  = 3'd5,
    WAIT_RES  = 3'd6,
    NEXT_PIX  = 3'd7
  } state_t;

  state_t                       state;
  logic [WORD_WIDTH-1:0]        obi_addr_q;
  logic [MEM_ACCESS_WIDTH-1:0]  obi_lim_q;
  logic                         obi_start_q;
  logic                         busy_q;
  logic [BATCH_WIDTH-1:0]       pix_q;
  logic                         cfg_err_q;
  logic                         interrupt_q;

  logic [HSP_BANDS_WIDTH-1:0]   bands_q;
  logic [HSP_LIBRARY_WIDTH-1:0] lib_size_q;
  logic [BATCH_WIDTH-1:0]       batch_q;
  logic [WORD_WIDTH-1:0]        cap_addr_q;
  logic [WORD_WIDTH-1:0]        lib_addr_q;

  // One extra bit keeps (bands+1) exact when bands is all-ones.
  logic [HSP_BANDS_WIDTH:0]     thr;
  logic [MEM_ACCESS_WIDTH-1:0]  cap_lim;
  logic [MEM_ACCESS_WIDTH-1:0]  lib_lim;
  logic [WORD_WIDTH-1:0]        cap_step;
  logic [WORD_WIDTH-1:0]        cap_addr_next;
  logic [BATCH_WIDTH-1:0]       pix_inc;
  logic                         abort;
  logic                         wd_expire;

  assign thr           = ({1'b0, bands_q} + (HSP_BANDS_WIDTH+1)'(1)) >> 1;
  assign cap_lim       = MEM_ACCESS_WIDTH'(thr);
  assign lib_lim       = MEM_ACCESS_WIDTH'({{HSP_LIBRARY_WIDTH{1'b0}}, thr} *
                                           {{(HSP_BANDS_WIDTH+1){1'b0}}, lib_size_q});
  assign cap_step      = WORD_WIDTH'({thr, 2'b00});
  assign cap_addr_next = cap_addr_q + cap_step;
  assign pix_inc       = pix_q + BATCH_WIDTH'(1);
  assign abort         = (state != IDLE) && (clear || error);

`ifdef HSID_X_BATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_wait;
  logic            timeout_q;

  // Counter only advances while sitting in a wait state, so any exit resets it.
  assign wd_wait   = (((state == READ_CAP) || (state == READ_LIB)) && !obi.obi_done) ||
                     ((state == WAIT_RES) && !pixel_done);
  assign wd_expire = wd_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      obi_addr_q  <= '0;
      obi_lim_q   <= MEM_ACCESS_WIDTH'(1);
      obi_start_q <= 1'b0;
      busy_q      <= 1'b0;
      pix_q       <= '0;
      cfg_err_q   <= 1'b0;
      interrupt_q <= 1'b0;
      bands_q     <= '0;
      lib_size_q  <= '0;
      batch_q     <= '0;
      cap_addr_q  <= '0;
      lib_addr_q  <= '0;
`ifdef HSID_X_BATCH_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      obi_start_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      interrupt_q <= 1'b0;
`ifdef HSID_X_BATCH_TIMEOUT_EN
      timeout_q   <= 1'b0;
      wd_cnt      <= wd_wait ? wd_cnt + WD_W'(1) : '0;
`endif
      if (abort) begin
        state       <= IDLE;
        busy_q      <= 1'b0;
        interrupt_q <= error;
      end else if (wd_expire) begin
        state       <= IDLE;
        busy_q      <= 1'b0;
        interrupt_q <= 1'b1;
`ifdef HSID_X_BATCH_TIMEOUT_EN
        timeout_q   <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= CONFIG;
              busy_q     <= 1'b1;
              pix_q      <= '0;
              bands_q    <= hsp_bands;
              lib_size_q <= hsp_library_size;
              batch_q    <= batch_size;
              cap_addr_q <= captured_pixel_addr;
              lib_addr_q <= library_pixel_addr;
            end
          end
          CONFIG: begin
            if ((bands_q == '0) || (lib_size_q == '0) || (batch_q == '0)) begin
              state       <= IDLE;
              busy_q      <= 1'b0;
              cfg_err_q   <= 1'b1;
              interrupt_q <= 1'b1;
            end else begin
              state       <= START_CAP;
              obi_start_q <= 1'b1;
              obi_addr_q  <= cap_addr_q;
              obi_lim_q   <= cap_lim;
            end
          end
          START_CAP: state <= READ_CAP;
          READ_CAP: begin
            if (obi.obi_done) begin
              state       <= START_LIB;
              obi_start_q <= 1'b1;
              obi_addr_q  <= lib_addr_q;
              obi_lim_q   <= lib_lim;
            end
          end
          START_LIB: state <= READ_LIB;
          READ_LIB: begin
            if (obi.obi_done) state <= WAIT_RES;
          end
          WAIT_RES: begin
            if (pixel_done) state <= NEXT_PIX;
          end
          NEXT_PIX: begin
            cap_addr_q <= cap_addr_next;
            pix_q      <= pix_inc;
            if (pix_inc == batch_q) begin
              state       <= IDLE;
              busy_q      <= 1'b0;
              interrupt_q <= 1'b1;
            end else begin
              state       <= START_CAP;
              obi_start_q <= 1'b1;
              obi_addr_q  <= cap_addr_next;
              obi_lim_q   <= cap_lim;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign obi.obi_initial_addr = obi_addr_q;
  assign obi.obi_limit_in     = obi_lim_q;
  assign obi.obi_start        = obi_start_q;
  assign busy                 = busy_q;
  assign pixel_index          = pix_q;
  assign cfg_err              = cfg_err_q;
  assign interrupt            = interrupt_q;

endmodule

// File: tb/tb_hsid_x_batch_fsm.sv
// Directed bench for hsid_x_batch_fsm: full batch, config errors, clear/error aborts, watchdog, mid-run reset.
module tb_hsid_x_batch_fsm;

  logic        clk;
  logic        rst;
  logic [7:0]  hsp_bands;
  logic [7:0]  hsp_library_size;
  logic [7:0]  batch_size;
  logic [31:0] captured_pixel_addr;
  logic [31:0] library_pixel_addr;
  logic        start;
  logic        clear;
  logic        error;
  logic        pixel_done;
  logic        busy;
  logic [7:0]  pixel_index;
  logic        cfg_err;
  logic        timeout_err;
  logic        interrupt;

  hsid_x_batch_fsm_if #(.WORD_WIDTH(32), .MEM_ACCESS_WIDTH(16)) obi_if ();

  hsid_x_batch_fsm #(
    .WORD_WIDTH(32), .HSP_BANDS_WIDTH(8), .HSP_LIBRARY_WIDTH(8),
    .MEM_ACCESS_WIDTH(16), .BATCH_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .hsp_bands           (hsp_bands),
    .hsp_library_size    (hsp_library_size),
    .batch_size          (batch_size),
    .captured_pixel_addr (captured_pixel_addr),
    .library_pixel_addr  (library_pixel_addr),
    .start               (start),
    .clear               (clear),
    .error               (error),
    .pixel_done          (pixel_done),
    .obi                 (obi_if.master),
    .busy                (busy),
    .pixel_index         (pixel_index),
    .cfg_err             (cfg_err),
    .timeout_err         (timeout_err),
    .interrupt           (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] st_addr[$];
  logic [15:0] st_lim[$];
  int int_cnt = 0;
  int cfg_cnt = 0;
  int to_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (obi_if.obi_start === 1'b1) begin
      st_addr.push_back(obi_if.obi_initial_addr);
      st_lim.push_back(obi_if.obi_limit_in);
    end
    if (interrupt === 1'b1)   int_cnt++;
    if (cfg_err === 1'b1)     cfg_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
  end

  task automatic clr_mon();
    st_addr.delete();
    st_lim.delete();
    int_cnt = 0;
    cfg_cnt = 0;
    to_cnt  = 0;
  endtask

  task automatic set_cfg(input logic [7:0] b, input logic [7:0] l, input logic [7:0] n,
                         input logic [31:0] ca, input logic [31:0] la);
    hsp_bands           = b;
    hsp_library_size    = l;
    batch_size          = n;
    captured_pixel_addr = ca;
    library_pixel_addr  = la;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy === 1'b0), 32'd1);
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (st_addr.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(st_addr.size() >= n), 32'd1);
  endtask

  task automatic run_batch(input string tag);
    logic [31:0] exp_addr [4];
    logic [15:0] exp_lim  [4];
    exp_addr = '{32'h1000, 32'h2000, 32'h1008, 32'h2000};
    exp_lim  = '{16'd2, 16'd6, 16'd2, 16'd6};
    set_cfg(8'd4, 8'd3, 8'd2, 32'h1000, 32'h2000);
    obi_if.obi_done = 1'b1;
    pixel_done      = 1'b1;
    clr_mon();
    pulse_start();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_idle({tag, "_done"});
    @(negedge clk);
    check({tag, "_nstart"}, st_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), (i < st_addr.size()) ? st_addr[i] : 32'hDEAD_BEEF, exp_addr[i]);
      check($sformatf("%s_lim%0d", tag, i), (i < st_lim.size()) ? 32'(st_lim[i]) : 32'hDEAD_BEEF, 32'(exp_lim[i]));
    end
    check({tag, "_irq"}, int_cnt, 32'd1);
    check({tag, "_cfgerr"}, cfg_cnt, 32'd0);
    check({tag, "_pix"}, 32'(pixel_index), 32'd2);
    check({tag, "_hold_addr"}, obi_if.obi_initial_addr, 32'h2000);
    check({tag, "_hold_lim"}, 32'(obi_if.obi_limit_in), 32'd6);
    obi_if.obi_done = 1'b0;
    pixel_done      = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ostart"}, 32'(obi_if.obi_start), 32'd0);
    check({tag, "_addr"}, obi_if.obi_initial_addr, 32'd0);
    check({tag, "_lim"}, 32'(obi_if.obi_limit_in), 32'd1);
    check({tag, "_pix"}, 32'(pixel_index), 32'd0);
    check({tag, "_cfgerr"}, 32'(cfg_err), 32'd0);
    check({tag, "_toerr"}, 32'(timeout_err), 32'd0);
    check({tag, "_irq"}, 32'(interrupt), 32'd0);
  endtask

  logic [7:0] zb [3];
  logic [7:0] zl [3];
  logic [7:0] zn [3];

  initial begin
    rst = 1'b1;
    start = 1'b0; clear = 1'b0; error = 1'b0; pixel_done = 1'b0;
    obi_if.obi_done = 1'b0;
    set_cfg(8'd0, 8'd0, 8'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Nominal two-pixel batch.
    run_batch("batch");

    // Any zero configuration field aborts in CONFIG.
    zb = '{8'd0, 8'd4, 8'd4};
    zl = '{8'd3, 8'd0, 8'd3};
    zn = '{8'd2, 8'd2, 8'd0};
    for (int i = 0; i < 3; i++) begin
      set_cfg(zb[i], zl[i], zn[i], 32'h1000, 32'h2000);
      clr_mon();
      pulse_start();
      @(negedge clk);
      check($sformatf("cfg%0d_err", i), 32'(cfg_err), 32'd1);
      check($sformatf("cfg%0d_irq", i), 32'(interrupt), 32'd1);
      check($sformatf("cfg%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("cfg%0d_pix", i), 32'(pixel_index), 32'd0);
      @(negedge clk);
      check($sformatf("cfg%0d_err_pulse", i), 32'(cfg_err), 32'd0);
      check($sformatf("cfg%0d_nirq", i), int_cnt, 32'd1);
      check($sformatf("cfg%0d_nstart", i), st_addr.size(), 32'd0);
    end

    // Clear in READ_LIB beats a coincident obi_done.
    set_cfg(8'd4, 8'd3, 8'd2, 32'h1000, 32'h2000);
    clr_mon();
    pulse_start();
    wait_starts(1, "clr_cap_start");
    @(negedge clk) obi_if.obi_done = 1'b1;
    @(negedge clk) obi_if.obi_done = 1'b0;
    @(negedge clk) begin obi_if.obi_done = 1'b1; clear = 1'b1; end
    @(negedge clk) begin obi_if.obi_done = 1'b0; clear = 1'b0; end
    check("clr_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("clr_nirq", int_cnt, 32'd0);
    check("clr_nstart", st_addr.size(), 32'd2);

    // Error during WAIT_RES of the second of three pixels.
    set_cfg(8'd4, 8'd3, 8'd3, 32'h1000, 32'h2000);
    obi_if.obi_done = 1'b1;
    clr_mon();
    pulse_start();
    wait_starts(2, "err_lib0");
    repeat (2) @(negedge clk);
    pixel_done = 1'b1;
    @(negedge clk) pixel_done = 1'b0;
    wait_starts(4, "err_lib1");
    repeat (2) @(negedge clk);
    error = 1'b1;
    @(negedge clk) error = 1'b0;
    check("err_irq", 32'(interrupt), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_pix", 32'(pixel_index), 32'd1);
    check("err_addr1", (st_addr.size() > 2) ? st_addr[2] : 32'hDEAD_BEEF, 32'h1008);
    obi_if.obi_done = 1'b0;
    @(negedge clk);
    check("err_nirq", int_cnt, 32'd1);

    // obi_done withheld in READ_CAP; start there is ignored.
    set_cfg(8'd4, 8'd3, 8'd2, 32'h1000, 32'h2000);
    clr_mon();
    pulse_start();
    wait_starts(1, "to_cap_start");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    check("to_busy_before", 32'(busy), 32'd1);
    check("to_err_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
`ifdef HSID_X_BATCH_TIMEOUT_EN
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_irq", 32'(interrupt), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
`else
    repeat (20) @(negedge clk);
    check("to_stuck_busy", 32'(busy), 32'd1);
    check("to_no_err", to_cnt, 32'd0);
    check("to_no_irq", int_cnt, 32'd0);
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("to_clear_busy", 32'(busy), 32'd0);
`endif
    check("to_nstart", st_addr.size(), 32'd1);

    // Asynchronous reset while in READ_CAP.
    @(negedge clk);
    clr_mon();
    pulse_start();
    wait_starts(1, "rst_cap_start");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_nstart", st_addr.size(), 32'd1);
    check("rst_nirq", int_cnt, 32'd0);
    run_batch("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
